reg_write_arbiter: RTL and testbench

Shares the single register-block write port (`We`, `Rw`, `WData`) between `NREQ` independent writeback sources, such as ALU result, memory load and PC-link writes. It runs round-robin arbitration with a per-requester request/grant handshake. It registers the winning write onto the register-block write port one cycle after grant, and discards writes to register 0. It sits between the writeback sources and `regBlock`.

---
 rtl/reg_write_arbiter.sv | 85 ++++++++
 tb/tb_reg_write_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-block write port between NREQ writeback sources.
// Define REG_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module reg_write_arbiter #(
    parameter int n            = 16,
    parameter int addr_size    = 3,
    parameter int NREQ         = 4,
    parameter int ZERO_DISCARD = 1
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Enable,
    input  logic [NREQ-1:0]           Req,
    input  logic [NREQ*addr_size-1:0] ReqAddr,
    input  logic [NREQ*n-1:0]         ReqData,
    output logic [NREQ-1:0]           Gnt,
    output logic                      We,
    output logic [addr_size-1:0]      Rw,
    output logic [n-1:0]              WData,
    output logic [$clog2(NREQ)-1:0]   LastGnt
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]        ptr;
    logic [IW-1:0]        sel;
    logic                 any;
    logic [addr_size-1:0] sel_addr;
    logic [n-1:0]         sel_data;
    int unsigned          idx;

    // Search upward from ptr with wrap; only Req/Enable/Reset/ptr feed the grant.
    always_comb begin
        Gnt = '0;
        sel = '0;
        any = 1'b0;
        idx = 0;
        if (!Reset && Enable) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = 32'(ptr) + k;
                if (idx >= 32'(NREQ))
                    idx = idx - 32'(NREQ);
                if (!any && Req[idx[IW-1:0]]) begin
                    any = 1'b1;
                    sel = idx[IW-1:0];
                end
            end
            if (any)
                Gnt[sel] = 1'b1;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel == IW'(i)) begin
                sel_addr = ReqAddr[i*addr_size +: addr_size];
                sel_data = ReqData[i*n +: n];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr     <= '0;
            LastGnt <= '0;
            We      <= 1'b0;
            Rw      <= '0;
            WData   <= '0;
        end else begin
            We <= any && !((ZERO_DISCARD != 0) && (sel_addr == '0));
            if (any) begin
                Rw      <= sel_addr;
                WData   <= sel_data;
                LastGnt <= sel;
`ifdef REG_ARB_FIXED_PRIO_EN
                ptr     <= '0;
`else
                ptr     <= (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed vectors push expected writes, a monitor pops them.
module tb_reg_write_arbiter;

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic [3:0]  Req;
    logic [11:0] ReqAddr;
    logic [63:0] ReqData;
    logic [3:0]  Gnt;
    logic        We;
    logic [2:0]  Rw;
    logic [15:0] WData;
    logic [1:0]  LastGnt;

    logic [2:0]  addr_of [4];
    logic [15:0] data_of [4];
    logic [15:0] regs    [8];
    logic [18:0] exp_q   [$];
    int          passed;
    int          total;

    reg_write_arbiter #(.n(16), .addr_size(3), .NREQ(4), .ZERO_DISCARD(1)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enable  (Enable),
        .Req     (Req),
        .ReqAddr (ReqAddr),
        .ReqData (ReqData),
        .Gnt     (Gnt),
        .We      (We),
        .Rw      (Rw),
        .WData   (WData),
        .LastGnt (LastGnt)
    );

    always #5 Clock = ~Clock;

    always_comb begin
        ReqAddr = '0;
        ReqData = '0;
        for (int i = 0; i < 4; i++) begin
            ReqAddr[i*3 +: 3]   = addr_of[i];
            ReqData[i*16 +: 16] = data_of[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every presented write must match the oldest expected one.
    always @(negedge Clock) begin
        logic [18:0] e;
        if (We === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {13'd0, Rw, WData}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_port", {13'd0, Rw, WData}, {13'd0, e});
            end
            regs[Rw] = WData;
        end
    end

    // One clock of stimulus: drive, check the combinational grant, push the expected write, step.
    task automatic cycle(input logic [3:0] req, input logic en, input logic rst, input logic [3:0] exp_gnt);
        int g;
        Req    = req;
        Enable = en;
        Reset  = rst;
        #1;
        chk("gnt", {28'd0, Gnt}, {28'd0, exp_gnt});
        g = -1;
        for (int i = 0; i < 4; i++)
            if (exp_gnt[i]) g = i;
        if (g >= 0 && addr_of[g] != 3'd0)
            exp_q.push_back({addr_of[g], data_of[g]});
        @(posedge Clock);
        #1;
        if (rst) begin
            chk("rst_we", {31'd0, We}, 32'd0);
            chk("rst_rw_wdata", {13'd0, Rw, WData}, 32'd0);
            chk("rst_lastgnt", {30'd0, LastGnt}, 32'd0);
        end else if (g >= 0) begin
            chk("lastgnt", {30'd0, LastGnt}, g);
        end
    endtask

    initial begin
        Clock  = 1'b0;
        Reset  = 1'b1;
        Enable = 1'b1;
        Req    = 4'b0000;
        passed = 0;
        total  = 0;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            addr_of[i] = 3'(i + 1);
            data_of[i] = 16'hA000 + 16'(i);
        end
        @(posedge Clock);
        #1;

        // Reset held with all requests pending
        cycle(4'b1111, 1'b1, 1'b1, 4'b0000);
        cycle(4'b1111, 1'b1, 1'b1, 4'b0000);

        // Round-robin rotation from Ptr=0
        cycle(4'b1111, 1'b1, 1'b0, 4'b0001);
        cycle(4'b1111, 1'b1, 1'b0, 4'b0010);
        cycle(4'b1111, 1'b1, 1'b0, 4'b0100);
        cycle(4'b1111, 1'b1, 1'b0, 4'b1000);
        cycle(4'b1111, 1'b1, 1'b0, 4'b0001);
        cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
        cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
        chk("reg3_after_rr", {16'd0, regs[3]}, 32'h0000_A002);

        // Zero-address write is consumed without asserting We (Ptr=1 here)
        addr_of[2] = 3'd0;
        data_of[2] = 16'hBEEF;
        cycle(4'b0100, 1'b1, 1'b0, 4'b0100);
        cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
        cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
        chk("reg0_unchanged", {16'd0, regs[0]}, 32'd0);

        // Enable stall: request pending, then released
        addr_of[2] = 3'd6;
        data_of[2] = 16'hC0DE;
        for (int i = 0; i < 5; i++)
            cycle(4'b0100, 1'b0, 1'b0, 4'b0000);
        cycle(4'b0100, 1'b1, 1'b0, 4'b0100);
        cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
        cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
        chk("reg6_after_stall", {16'd0, regs[6]}, 32'h0000_C0DE);

        // Reset with pending requests, then same-address race from Ptr=0
        addr_of[1] = 3'd5;
        data_of[1] = 16'h1111;
        addr_of[3] = 3'd5;
        data_of[3] = 16'h3333;
        cycle(4'b1010, 1'b1, 1'b1, 4'b0000);
        cycle(4'b1010, 1'b1, 1'b0, 4'b0010);
        cycle(4'b1000, 1'b1, 1'b0, 4'b1000);
        cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
        cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
        chk("reg5_race", {16'd0, regs[5]}, 32'h0000_3333);

        // Lone requester may be granted back-to-back; Ptr=0 after grant to 3
        cycle(4'b0001, 1'b1, 1'b0, 4'b0001);
        cycle(4'b0001, 1'b1, 1'b0, 4'b0001);
        cycle(4'b0011, 1'b1, 1'b0, 4'b0010);
        cycle(4'b0000, 1'b1, 1'b0, 4'b0000);
        cycle(4'b0000, 1'b1, 1'b0, 4'b0000);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
